mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the pipelined ARM core's fetch port (PCF/InstrF) and data port (ALUOutM/WriteDataM/ReadDataM).
- Serialises requests and returns per-port completion pulses, which the hazard logic uses as stall conditions.
- Enforces a starvation limit so fetch always progresses.
- Enforces a watchdog timeout on the memory handshake.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory between the core's
//   instruction fetch port and its data port. One access is outstanding at a
//   time; each completes with a one-cycle ready pulse on the owning port.
//   Data normally wins a tie, but after STARVE_LIMIT consecutive data grants
//   with fetch waiting, fetch is granted. A BUSY access that sees no mem_ack
//   within TIMEOUT cycles is aborted: the owner gets ready with rdata=0 and
//   the sticky err flag is raised.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-low reset
//   if_req/if_addr         fetch request (held until if_ready) and address
//   if_rdata/if_ready      fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr      data request (held until d_ready), 1=store, address
//   d_wdata                store data
//   d_rdata/d_ready        load data, one-cycle completion pulse
//   mem_req/mem_we         memory request (held until ack/timeout), write enable
//   mem_addr/mem_wdata     memory address and write data
//   mem_rdata/mem_ack      memory read data, one-cycle completion
//   err                    sticky timeout flag, cleared only by reset
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  state_t        r_state;
  logic          r_owner;       // 0 = fetch, 1 = data
  logic [SW-1:0] r_starve_cnt;
  logic [WW-1:0] r_wait_cnt;

  logic w_grant_d;
  logic w_timeout;

  assign w_grant_d = d_req && (!if_req || (r_starve_cnt < STARVE_MAX));
  assign w_timeout = (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_starve_cnt <= '0;
      r_wait_cnt   <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rdata     <= '0;
      if_ready     <= 1'b0;
      d_rdata      <= '0;
      d_ready      <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (w_grant_d) begin
            r_state   <= BUSY_D;
            r_owner   <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // Only a data grant that bypasses a waiting fetch counts toward
            // starvation; the limit check above keeps this from overflowing.
            r_starve_cnt <= if_req ? r_starve_cnt + 1'b1 : '0;
          end else if (if_req) begin
            r_state      <= BUSY_I;
            r_owner      <= 1'b0;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= if_addr;
            r_starve_cnt <= '0;
          end else begin
            r_starve_cnt <= '0;
          end
        end

        BUSY_I, BUSY_D: begin
          if (mem_ack) begin
            r_state    <= RESP;
            r_wait_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            if (r_owner) begin
              d_ready <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (w_timeout) begin
            r_state    <= RESP;
            r_wait_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            err        <= 1'b1;
            if (r_owner) begin
              d_ready <= 1'b1;
              d_rdata <= '0;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= '0;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        RESP: begin
          r_state  <= IDLE;
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized phase, all compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;
  localparam int unsigned TO = 15;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          err;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // m_phase: 0 = waiting for a request, 1 = access outstanding, 2 = response cycle
  int unsigned m_phase;
  bit          m_to_data;
  int unsigned m_starve;   // data grants taken while fetch was waiting
  int unsigned m_hold;     // cycles mem_req has been up for the current access

  logic          e_mem_req, e_mem_we, e_if_ready, e_d_ready, e_err;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_if_rdata, e_d_rdata;

  // memory responder state
  int unsigned lat;        // ack is driven in this cycle number of mem_req
  bit          no_ack;
  bit          rand_lat;
  bit          spurious;
  logic [DW-1:0] memory [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_read(logic [AW-1:0] a);
    if (memory.exists(a)) return memory[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function void model_reset();
    m_phase = 0; m_to_data = 0; m_starve = 0; m_hold = 0;
    e_mem_req = 0; e_mem_we = 0; e_if_ready = 0; e_d_ready = 0; e_err = 0;
    e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
  endfunction

  function void finish_access(bit aborted, logic [DW-1:0] data);
    if (m_to_data) begin
      e_d_ready = 1;
      if (aborted) e_d_rdata = '0;
      else if (!e_mem_we) e_d_rdata = data;
    end else begin
      e_if_ready = 1;
      e_if_rdata = aborted ? '0 : data;
    end
    if (aborted) e_err = 1;
    e_mem_req = 0;
    e_mem_we  = 0;
    m_phase   = 2;
  endfunction

  // Called at each rising edge with the inputs that were applied in the cycle.
  function void model_edge();
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_phase == 0) begin
      if (!if_req) m_starve = 0;
      if (d_req && (!if_req || m_starve < SL)) begin
        m_to_data = 1;
        e_mem_we = d_we; e_mem_addr = d_addr; e_mem_wdata = d_wdata;
        if (if_req) m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
      end else if (if_req) begin
        m_to_data = 0;
        e_mem_we = 0; e_mem_addr = if_addr;
        m_starve = 0;
      end
      if (d_req || if_req) begin
        m_phase = 1; e_mem_req = 1; m_hold = 0;
      end
    end else if (m_phase == 1) begin
      m_hold = m_hold + 1;
      if (mem_ack) finish_access(0, mem_rdata);
      else if (m_hold == TO) finish_access(1, '0);
    end else begin
      m_phase = 0; e_if_ready = 0; e_d_ready = 0;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("mem_req",   32'(mem_req),   32'(e_mem_req));
    check("mem_we",    32'(mem_we),    32'(e_mem_we));
    check("mem_addr",  mem_addr,       e_mem_addr);
    check("mem_wdata", mem_wdata,      e_mem_wdata);
    check("if_ready",  32'(if_ready),  32'(e_if_ready));
    check("if_rdata",  if_rdata,       e_if_rdata);
    check("d_ready",   32'(d_ready),   32'(e_d_ready));
    check("d_rdata",   d_rdata,        e_d_rdata);
    check("err",       32'(err),       32'(e_err));
  endtask

  // Drives mem_ack/mem_rdata for the cycle that has just begun.
  task automatic mem_drive();
    mem_ack   = 0;
    mem_rdata = $urandom();
    if (m_phase == 1) begin
      if (rand_lat && m_hold == 0) begin
        lat    = $urandom_range(1, 5);
        no_ack = ($urandom_range(0, 19) == 0);
      end
      if (!no_ack && m_hold + 1 == lat) begin
        mem_ack = 1;
        if (e_mem_we) memory[e_mem_addr] = e_mem_wdata;
        else mem_rdata = mem_read(e_mem_addr);
      end
    end else if (spurious) begin
      mem_ack = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    mem_drive();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit found;
    bit prev_req;
    int unsigned grants;
    byte kinds [6];
    bit f_pend, d_pend;

    reset = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; mem_ack = 0; mem_rdata = '0;
    lat = 1; no_ack = 0; rand_lat = 0; spurious = 0;
    model_reset();

    // Reset state
    #2;
    compare_all();
    repeat (2) cycle();
    reset = 1;
    repeat (2) cycle();

    // Fetch only: ack in the third mem_req cycle, ready on the 4th cycle
    lat = 3;
    memory[32'h100] = 32'hE3A0_0001;
    if_addr = 32'h100; if_req = 1;
    found = 0; n = 0;
    for (int i = 1; i <= 10 && !found; i++) begin
      cycle();
      if (i == 1) begin
        check("fetch_mem_addr", mem_addr, 32'h100);
        check("fetch_mem_we", 32'(mem_we), 32'd0);
      end
      if (if_ready === 1'b1) begin found = 1; n = i; end
    end
    check("fetch_ready_seen", 32'(found), 32'd1);
    check("fetch_latency", 32'(n), 32'd4);
    check("fetch_rdata", if_rdata, 32'hE3A0_0001);
    if_req = 0;
    cycle();
    check("fetch_ready_pulse", 32'(if_ready), 32'd0);
    cycle();

    // Simultaneous requests: store first, fetch granted one cycle after RESP
    lat = 1;
    if_addr = 32'h104; if_req = 1;
    d_we = 1; d_addr = 32'h2000; d_wdata = 32'hCAFE_F00D; d_req = 1;
    cycle();
    check("sim_store_we", 32'(mem_we), 32'd1);
    check("sim_store_addr", mem_addr, 32'h2000);
    check("sim_store_wdata", mem_wdata, 32'hCAFE_F00D);
    cycle();
    check("sim_d_ready", 32'(d_ready), 32'd1);
    check("sim_if_ready_low", 32'(if_ready), 32'd0);
    d_req = 0; d_we = 0;
    cycle();
    check("sim_idle_gap", 32'(mem_req), 32'd0);
    cycle();
    check("sim_fetch_req", 32'(mem_req), 32'd1);
    check("sim_fetch_addr", mem_addr, 32'h104);
    cycle();
    check("sim_fetch_ready", 32'(if_ready), 32'd1);
    check("sim_fetch_rdata", if_rdata, 32'h104 ^ 32'h5A5A_0F0F);
    if_req = 0;
    cycle();

    // Starvation: fetch held, data re-asserted continuously
    lat = 1;
    if_addr = 32'h300; if_req = 1;
    d_we = 0; d_addr = 32'h4000; d_req = 1;
    grants = 0; prev_req = 0;
    for (int i = 0; i < 60 && grants < 6; i++) begin
      cycle();
      if (mem_req && !prev_req) begin
        kinds[grants] = (mem_addr < 32'h1000) ? "F" : "D";
        grants++;
      end
      prev_req = mem_req;
      if (d_ready) d_addr = d_addr + 32'd4;
      if (if_ready) if_addr = 32'h304;
    end
    check("starve_grants", grants, 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("starve_grant_%0d", i), 32'(kinds[i]), (i == 4) ? 32'("F") : 32'("D"));
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (d_ready) found = 1;
    end
    check("starve_drain", 32'(found), 32'd1);
    d_req = 0; if_req = 0;
    repeat (2) cycle();

    // Timeout on a load
    no_ack = 1;
    d_we = 0; d_addr = 32'h5000; d_req = 1;
    n = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (mem_req) n++;
      if (d_ready) found = 1;
    end
    check("to_ready_seen", 32'(found), 32'd1);
    check("to_req_cycles", 32'(n), 32'd15);
    check("to_rdata", d_rdata, 32'd0);
    check("to_err", 32'(err), 32'd1);
    d_req = 0; no_ack = 0;
    cycle();
    lat = 2; if_addr = 32'h100; if_req = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (if_ready) found = 1;
    end
    check("to_after_ready", 32'(found), 32'd1);
    check("to_err_sticky", 32'(err), 32'd1);
    if_req = 0;
    cycle();

    // Reset asserted in the middle of a data access
    lat = 10;
    d_we = 1; d_addr = 32'h6000; d_wdata = 32'h1234_5678; d_req = 1;
    repeat (2) cycle();
    check("rst_busy_req", 32'(mem_req), 32'd1);
    #3;
    reset = 0;
    #1;
    model_reset();
    compare_all();
    check("rst_async_req", 32'(mem_req), 32'd0);
    check("rst_async_err", 32'(err), 32'd0);
    d_req = 0; d_we = 0;
    cycle();
    reset = 1;
    // stale ack while idle must be ignored
    spurious = 1; mem_ack = 1;
    repeat (2) cycle();
    check("spur_if_ready", 32'(if_ready), 32'd0);
    check("spur_d_ready", 32'(d_ready), 32'd0);
    spurious = 0;
    cycle();
    lat = 2; if_addr = 32'h104; if_req = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (if_ready) found = 1;
    end
    check("rst_first_grant", 32'(found), 32'd1);
    check("rst_first_rdata", if_rdata, 32'h104 ^ 32'h5A5A_0F0F);
    if_req = 0;
    cycle();

    // Randomized traffic
    rand_lat = 1;
    f_pend = 0; d_pend = 0;
    for (int i = 0; i < 500; i++) begin
      cycle();
      if (e_if_ready) f_pend = 0;
      if (e_d_ready) d_pend = 0;
      if (!f_pend && $urandom_range(0, 2) == 0) begin
        f_pend = 1;
        if_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = 32'h8000 + (32'($urandom_range(0, 15)) << 2);
        d_wdata = $urandom();
      end
      if_req = f_pend;
      d_req = d_pend;
    end
    if_req = 0; d_req = 0;
    repeat (25) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
